// File: rtl/sha_msched_ctrl.sv
// SHA-256 message schedule sequencer: loads W[0..15], expands W[16..ROUNDS-1]
// on a shared ALU and streams every word in index order.
package sha_msched_ctrl_pkg;
    typedef enum logic [1:0] {
        kADDU = 2'd0,
        kSSO  = 2'd1,
        kSSZ  = 2'd2
    } alu_opcode_e;

    typedef struct packed {
        alu_opcode_e opcode;
    } instruction_s;
endpackage

module sha_msched_ctrl
    import sha_msched_ctrl_pkg::*;
#(
    parameter int unsigned ROUNDS = 64,
    parameter int unsigned IDX_W  = 6
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              load_valid_i,
    input  logic [31:0]       load_word_i,
    output logic              load_ready_o,
    output logic              w_valid_o,
    output logic [31:0]       w_word_o,
    output logic [IDX_W-1:0]  w_index_o,
    input  logic              w_ready_i,
    output logic              alu_req_o,
    input  logic              alu_gnt_i,
    output instruction_s      alu_op_o,
    output logic [31:0]       alu_rd_o,
    output logic [31:0]       alu_rs_o,
    input  logic [31:0]       alu_result_i,
    output logic              busy_o,
    output logic              done_o
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned SLOT_W = 4;
    localparam int unsigned SLOTS  = 16;
    localparam logic [IDX_W-1:0] LAST_T = IDX_W'(ROUNDS - 1);
    localparam logic [IDX_W-1:0] LOAD_T = IDX_W'(15);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_SIG1, S_SIG0, S_ADD0, S_ADD1, S_ADD2, S_EMIT, S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    t_q, t_d;
    logic [WORD_W-1:0]   tmp1_q, tmp1_d, tmp0_q, tmp0_d, acc_q, acc_d;
    logic [WORD_W-1:0]   wbuf [SLOTS];
    logic                buf_we;
    logic [SLOT_W-1:0]   buf_waddr;
    logic [WORD_W-1:0]   buf_wdata;
    logic [SLOT_W-1:0]   slot;
    logic                alu_fire;

    logic                load_ready_d, w_valid_d, alu_req_d, busy_d, done_d;
    logic [WORD_W-1:0]   w_word_d, alu_rd_d, alu_rs_d;
    logic [IDX_W-1:0]    w_index_d;
    instruction_s        alu_op_d;

    // Next state, datapath updates, and next values of the registered outputs.
    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        tmp1_d    = tmp1_q;
        tmp0_d    = tmp0_q;
        acc_d     = acc_q;
        buf_we    = 1'b0;
        buf_waddr = t_q[SLOT_W-1:0];
        buf_wdata = alu_result_i;
        w_word_d  = w_word_o;
        w_index_d = w_index_o;
        alu_fire  = alu_req_o & alu_gnt_i;

        unique case (state_q)
            S_IDLE, S_LOAD: begin
                if (load_valid_i) begin
                    buf_we    = 1'b1;
                    buf_wdata = load_word_i;
                    w_word_d  = load_word_i;
                    w_index_d = t_q;
                    state_d   = S_EMIT;
                end
            end
            S_SIG1: if (alu_fire) begin tmp1_d = alu_result_i; state_d = S_SIG0; end
            S_SIG0: if (alu_fire) begin tmp0_d = alu_result_i; state_d = S_ADD0; end
            S_ADD0: if (alu_fire) begin acc_d  = alu_result_i; state_d = S_ADD1; end
            S_ADD1: if (alu_fire) begin acc_d  = alu_result_i; state_d = S_ADD2; end
            S_ADD2: begin
                if (alu_fire) begin
                    buf_we    = 1'b1;
                    w_word_d  = alu_result_i;
                    w_index_d = t_q;
                    state_d   = S_EMIT;
                end
            end
            S_EMIT: begin
                if (w_ready_i) begin
                    t_d = t_q + IDX_W'(1);
                    if (t_q == LAST_T)      state_d = S_DONE;
                    else if (t_q < LOAD_T)  state_d = S_LOAD;
                    else                    state_d = S_SIG1;
                end
            end
            S_DONE: begin
                t_d     = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the upcoming state so they leave registers.
        slot         = t_d[SLOT_W-1:0];
        load_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
        w_valid_d    = (state_d == S_EMIT);
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
        alu_req_d    = 1'b0;
        alu_op_d     = instruction_s'{opcode: kADDU};
        alu_rd_d     = '0;
        alu_rs_d     = '0;

        unique case (state_d)
            S_SIG1: begin
                alu_req_d = 1'b1;
                alu_op_d  = instruction_s'{opcode: kSSO};
                alu_rs_d  = wbuf[slot - SLOT_W'(2)];
            end
            S_SIG0: begin
                alu_req_d = 1'b1;
                alu_op_d  = instruction_s'{opcode: kSSZ};
                alu_rs_d  = wbuf[slot - SLOT_W'(15)];
            end
            S_ADD0: begin
                alu_req_d = 1'b1;
                alu_rd_d  = tmp1_d;
                alu_rs_d  = wbuf[slot - SLOT_W'(7)];
            end
            S_ADD1: begin
                alu_req_d = 1'b1;
                alu_rd_d  = acc_d;
                alu_rs_d  = tmp0_d;
            end
            S_ADD2: begin
                // W[t-16] lives in the slot W[t] is about to overwrite.
                alu_req_d = 1'b1;
                alu_rd_d  = acc_d;
                alu_rs_d  = wbuf[slot];
            end
            default: ;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            tmp1_q  <= '0;
            tmp0_q  <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            tmp1_q  <= tmp1_d;
            tmp0_q  <= tmp0_d;
            acc_q   <= acc_d;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            load_ready_o <= 1'b1;
            w_valid_o    <= 1'b0;
            w_word_o     <= '0;
            w_index_o    <= '0;
            alu_req_o    <= 1'b0;
            alu_op_o     <= instruction_s'{opcode: kADDU};
            alu_rd_o     <= '0;
            alu_rs_o     <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            load_ready_o <= load_ready_d;
            w_valid_o    <= w_valid_d;
            w_word_o     <= w_word_d;
            w_index_o    <= w_index_d;
            alu_req_o    <= alu_req_d;
            alu_op_o     <= alu_op_d;
            alu_rd_o     <= alu_rd_d;
            alu_rs_o     <= alu_rs_d;
            busy_o       <= busy_d;
            done_o       <= done_d;
        end
    end

    // 16-word circular schedule window; contents need no reset.
    always_ff @(posedge clk) begin
        if (buf_we && !reset_i) begin
            wbuf[buf_waddr] <= buf_wdata;
        end
    end
endmodule

// File: tb/tb_sha_msched_ctrl.sv
// Bench for sha_msched_ctrl: ROUNDS=64 and ROUNDS=17 builds against a
// whole-array schedule model and a behavioural ALU.
module tb_sha_msched_ctrl;
    import sha_msched_ctrl_pkg::*;

    localparam int unsigned IDX_W = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_i, load_valid, w_ready, gnt, sel17;
    logic [31:0] load_word;

    logic lv_a, rdy_a, gnt_a, lr_a, wv_a, req_a, busy_a, done_a;
    logic lv_b, rdy_b, gnt_b, lr_b, wv_b, req_b, busy_b, done_b;
    logic [31:0] ww_a, rd_a, rs_a, res_a, ww_b, rd_b, rs_b, res_b;
    logic [5:0]  wi_a;
    logic [4:0]  wi_b;
    instruction_s op_a, op_b;

    logic v_lr, v_wv, v_req, v_busy, v_done;
    logic [31:0] v_word, v_rd, v_rs;
    logic [IDX_W-1:0] v_idx;
    instruction_s v_op;

    int n_vec = 0;
    int n_bad = 0;
    int cur_t = 0;
    logic [31:0] blk   [16];
    logic [31:0] exp_w [64];
    logic [31:0] got_w [64];

    typedef struct {
        int          idx;
        logic [31:0] word;
    } vec_t;
    vec_t tbl [6];

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction
    function automatic logic [31:0] alu_f(input instruction_s op, input logic [31:0] rd, input logic [31:0] rs);
        case (op.opcode)
            kSSO:    return ssig1(rs);
            kSSZ:    return ssig0(rs);
            default: return rd + rs;
        endcase
    endfunction

    assign res_a = alu_f(op_a, rd_a, rs_a);
    assign res_b = alu_f(op_b, rd_b, rs_b);
    assign lv_a  = !sel17 && load_valid;
    assign rdy_a = !sel17 && w_ready;
    assign gnt_a = !sel17 && gnt;
    assign lv_b  = sel17 && load_valid;
    assign rdy_b = sel17 && w_ready;
    assign gnt_b = sel17 && gnt;

    assign v_lr   = sel17 ? lr_b   : lr_a;
    assign v_wv   = sel17 ? wv_b   : wv_a;
    assign v_req  = sel17 ? req_b  : req_a;
    assign v_busy = sel17 ? busy_b : busy_a;
    assign v_done = sel17 ? done_b : done_a;
    assign v_word = sel17 ? ww_b   : ww_a;
    assign v_rd   = sel17 ? rd_b   : rd_a;
    assign v_rs   = sel17 ? rs_b   : rs_a;
    assign v_idx  = sel17 ? {1'b0, wi_b} : wi_a;
    assign v_op   = sel17 ? op_b   : op_a;

    sha_msched_ctrl #(.ROUNDS(64), .IDX_W(6)) u_dut64 (
        .clk(clk), .reset_i(reset_i),
        .load_valid_i(lv_a), .load_word_i(load_word), .load_ready_o(lr_a),
        .w_valid_o(wv_a), .w_word_o(ww_a), .w_index_o(wi_a), .w_ready_i(rdy_a),
        .alu_req_o(req_a), .alu_gnt_i(gnt_a), .alu_op_o(op_a),
        .alu_rd_o(rd_a), .alu_rs_o(rs_a), .alu_result_i(res_a),
        .busy_o(busy_a), .done_o(done_a)
    );

    sha_msched_ctrl #(.ROUNDS(17), .IDX_W(5)) u_dut17 (
        .clk(clk), .reset_i(reset_i),
        .load_valid_i(lv_b), .load_word_i(load_word), .load_ready_o(lr_b),
        .w_valid_o(wv_b), .w_word_o(ww_b), .w_index_o(wi_b), .w_ready_i(rdy_b),
        .alu_req_o(req_b), .alu_gnt_i(gnt_b), .alu_op_o(op_b),
        .alu_rd_o(rd_b), .alu_rs_o(rs_b), .alu_result_i(res_b),
        .busy_o(busy_b), .done_o(done_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (t=%0d): got 0x%08h expected 0x%08h", name, cur_t, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_load_ready"}, 32'(v_lr),   32'd1);
        chk({tag, "_w_valid"},    32'(v_wv),   32'd0);
        chk({tag, "_alu_req"},    32'(v_req),  32'd0);
        chk({tag, "_busy"},       32'(v_busy), 32'd0);
        chk({tag, "_done"},       32'(v_done), 32'd0);
        chk({tag, "_w_word"},     v_word,      32'd0);
        chk({tag, "_w_index"},    32'(v_idx),  32'd0);
        chk({tag, "_alu_rd"},     v_rd,        32'd0);
        chk({tag, "_alu_rs"},     v_rs,        32'd0);
        chk({tag, "_alu_op"},     32'(v_op.opcode), 32'(kADDU));
    endtask

    function automatic void build_model();
        for (int i = 0; i < 16; i++) exp_w[i] = blk[i];
        for (int i = 16; i < 64; i++)
            exp_w[i] = ssig1(exp_w[i-2]) + exp_w[i-7] + ssig0(exp_w[i-15]) + exp_w[i-16];
    endfunction

    function automatic void set_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'd0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
    endfunction

    // gnt_mode: 0 always, 1 pattern 1,0,0, 2 random. rdy_mode: 0 always, 1 random, 2 stall 5 on W20.
    task automatic run_block(input int gnt_mode, input int rdy_mode, input int abort_at, input bit timing);
        int rounds, next_load, exp_idx, fires, gpat, stall_cnt, done_cnt, last_hs_cyc;
        int accept_cyc [16];
        bit presented, exp_busy, finished, done_due, aborted, exp_lr;
        bit prev_req_stall, prev_w_stall, lhs, whs, fire;
        instruction_s p_op;
        logic [31:0] p_rd, p_rs, p_word, hs_word, e_op, e_rd, e_rs, s1, s0;
        logic [IDX_W-1:0] p_idx;

        rounds = sel17 ? 17 : 64;
        next_load = 0; exp_idx = 0; fires = 0; gpat = 0; stall_cnt = 0;
        done_cnt = 0; last_hs_cyc = 0;
        presented = 0; exp_busy = 0; finished = 0; done_due = 0; aborted = 0;
        prev_req_stall = 0; prev_w_stall = 0;
        p_op = instruction_s'{opcode: kADDU}; p_rd = 0; p_rs = 0; p_word = 0; p_idx = 0;
        for (int i = 0; i < 16; i++) accept_cyc[i] = 0;
        for (int i = 0; i < 64; i++) got_w[i] = 32'hDEADBEEF;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            cur_t  = exp_idx;
            exp_lr = finished || (next_load == exp_idx && exp_idx < 16);
            chk("done_o", 32'(v_done), 32'(done_due));
            if (v_done) done_cnt++;
            chk("busy_o", 32'(v_busy), 32'(exp_busy));
            chk("load_ready_o", 32'(v_lr), 32'(exp_lr));
            if (finished) break;
            if (done_due) begin
                finished = 1; exp_busy = 0; done_due = 0;
            end

            if (prev_w_stall) begin
                chk("w_valid_held", 32'(v_wv), 32'd1);
                chk("w_word_held", v_word, p_word);
                chk("w_index_held", 32'(v_idx), 32'(p_idx));
            end
            if (prev_req_stall) begin
                chk("alu_req_held", 32'(v_req), 32'd1);
                chk("alu_op_held", 32'(v_op.opcode), 32'(p_op.opcode));
                chk("alu_rd_held", v_rd, p_rd);
                chk("alu_rs_held", v_rs, p_rs);
            end

            if (v_wv) begin
                chk("alu_req_in_emit", 32'(v_req), 32'd0);
                if (exp_idx >= rounds) begin
                    chk("w_valid_after_last", 32'(v_wv), 32'd0);
                end else begin
                    chk("w_index_o", 32'(v_idx), 32'(exp_idx));
                    chk("w_word_o", v_word, exp_w[exp_idx]);
                    if (!presented) begin
                        presented = 1;
                        chk("alu_ops_per_word", 32'(fires), (exp_idx >= 16) ? 32'd5 : 32'd0);
                        if (exp_idx < 16) chk("load_latency", 32'(cyc - accept_cyc[exp_idx]), 32'd1);
                        if (timing && exp_idx == 16) chk("w16_latency", 32'(cyc - last_hs_cyc), 32'd6);
                    end
                end
            end

            if (abort_at >= 0 && exp_idx == abort_at && fires == 3 && v_req) begin
                reset_i = 1; load_valid = 1; load_word = $urandom; w_ready = 1; gnt = 1;
                @(posedge clk); #1;
                check_reset_vals("abort");
                reset_i = 0; load_valid = 0; w_ready = 0; gnt = 0;
                aborted = 1;
                break;
            end

            case (gnt_mode)
                0:       gnt = 1'b1;
                1:       gnt = (gpat % 3 == 0);
                default: gnt = 1'($urandom_range(0, 1));
            endcase
            gpat++;
            case (rdy_mode)
                0: w_ready = 1'b1;
                1: w_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    w_ready = 1'b1;
                    if (v_wv && exp_idx == 20 && stall_cnt < 5) begin
                        w_ready = 1'b0;
                        stall_cnt++;
                    end
                end
            endcase
            if (next_load < 16) begin
                load_valid = (gnt_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
                load_word  = blk[next_load];
            end else begin
                load_valid = (gnt_mode == 2) && !finished && 1'($urandom_range(0, 1));
                load_word  = $urandom;
            end

            lhs  = v_lr && load_valid;
            whs  = v_wv && w_ready;
            fire = v_req && gnt;
            if (fire) begin
                if (exp_idx < 16 || exp_idx >= rounds || fires > 4) begin
                    chk("alu_fire_allowed", 32'(v_req), 32'd0);
                end else begin
                    s1 = ssig1(exp_w[exp_idx-2]);
                    s0 = ssig0(exp_w[exp_idx-15]);
                    case (fires)
                        0: begin e_op = 32'(kSSO);  e_rd = 0;                        e_rs = exp_w[exp_idx-2];  end
                        1: begin e_op = 32'(kSSZ);  e_rd = 0;                        e_rs = exp_w[exp_idx-15]; end
                        2: begin e_op = 32'(kADDU); e_rd = s1;                       e_rs = exp_w[exp_idx-7];  end
                        3: begin e_op = 32'(kADDU); e_rd = s1 + exp_w[exp_idx-7];    e_rs = s0;                end
                        default: begin e_op = 32'(kADDU); e_rd = s1 + exp_w[exp_idx-7] + s0; e_rs = exp_w[exp_idx-16]; end
                    endcase
                    chk("alu_op", 32'(v_op.opcode), e_op);
                    chk("alu_rd", v_rd, e_rd);
                    chk("alu_rs", v_rs, e_rs);
                end
                fires++;
            end
            prev_req_stall = v_req && !gnt;
            prev_w_stall   = v_wv && !w_ready;
            p_op = v_op; p_rd = v_rd; p_rs = v_rs; p_word = v_word; p_idx = v_idx;
            hs_word = v_word;

            @(posedge clk); #1;

            if (lhs) begin
                if (next_load < 16) accept_cyc[next_load] = cyc;
                next_load++;
                exp_busy = 1;
            end
            if (whs) begin
                if (exp_idx < 64) got_w[exp_idx] = hs_word;
                last_hs_cyc = cyc;
                exp_idx++;
                presented = 0;
                fires = 0;
                if (exp_idx == rounds) done_due = 1;
            end
        end

        load_valid = 0; w_ready = 0; gnt = 0;
        if (aborted) begin
            chk("done_in_abort", 32'(done_cnt), 32'd0);
        end else if (!finished) begin
            n_vec++; n_bad++;
            $display("FAIL run_timeout: stream stopped at t=%0d of %0d", exp_idx, rounds);
        end else begin
            chk("done_pulses", 32'(done_cnt), 32'd1);
        end
    endtask

    initial begin
        tbl[0] = '{0,  32'h61626380};
        tbl[1] = '{1,  32'h00000000};
        tbl[2] = '{15, 32'h00000018};
        tbl[3] = '{16, 32'h61626380};
        tbl[4] = '{17, 32'h000F0000};
        tbl[5] = '{63, 32'h12B1EDEB};

        sel17 = 0; reset_i = 1; load_valid = 0; load_word = 0; w_ready = 0; gnt = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset64");
        sel17 = 1; #0;
        check_reset_vals("reset17");
        sel17 = 0;
        reset_i = 0;

        // "abc" block, everything ready, with latency checks and known words.
        set_abc();
        build_model();
        run_block(0, 0, -1, 1);
        for (int i = 0; i < 6; i++)
            chk($sformatf("abc_W%0d", tbl[i].idx), got_w[tbl[i].idx], tbl[i].word);

        run_block(1, 0, -1, 0);     // grant toggling 1,0,0
        run_block(0, 2, -1, 0);     // consumer stalls on W20
        run_block(0, 0, 30, 0);     // reset while in ADD1 for t=30
        run_block(0, 0, -1, 1);     // reload after abort
        chk("abc_W63_after_abort", got_w[63], 32'h12B1EDEB);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) blk[i] = $urandom;
            build_model();
            run_block(2, 1, -1, 0);
        end

        sel17 = 1; #0;
        set_abc();
        build_model();
        run_block(0, 0, -1, 1);
        chk("r17_W16", got_w[16], 32'h61626380);
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        build_model();
        run_block(2, 1, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
